mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one memory port between the instruction-fetch requester and the data (load/store) requester.
- Supports a processor variant with a unified memory.
- One transaction outstanding at a time.
- Fixed priority: data wins over fetch, with an anti-starvation counter.
- Produces a stall signal that holds the PC while a fetch is pending.

Parameters:
- ADDR_W, 32, address width for all address ports.
- DATA_W, 32, data width; must be a multiple of 8.
- MAX_WAIT, 4, consecutive arbitration losses by fetch before fetch is forced to win; range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- if_req  input  1  fetch request; held, with if_addr stable, until if_gnt.
- if_addr  input  ADDR_W  fetch address.
- if_gnt  output  1  one-cycle pulse: fetch request accepted.
- if_rvalid  output  1  fetch data valid, one cycle.
- if_rdata  output  DATA_W  fetch data.
- d_req  input  1  data request; held, with attributes stable, until d_gnt.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  store data.
- d_be  input  DATA_W/8  store byte enables.
- d_gnt  output  1  one-cycle pulse: data request accepted.
- d_rvalid  output  1  load data valid or store acknowledge, one cycle.
- d_rdata  output  DATA_W  load data.
- mem_req  output  1  request to memory.
- mem_we  output  1  write enable to memory.
- mem_addr  output  ADDR_W  address to memory.
- mem_wdata  output  DATA_W  write data to memory.
- mem_be  output  DATA_W/8  byte enables to memory.
- mem_gnt  input  1  memory accepts request this cycle.
- mem_rvalid  input  1  memory response; for writes, acknowledge only.
- mem_rdata  input  DATA_W  memory read data.
- stall  output  1  hold PC; combinational: if_req & ~if_rvalid.

Behaviour:
- Reset: clk is the only clock; rst is synchronous and active-low.
  - While rst=0 at a clk edge: state <= IDLE, owner <= none, starve_cnt <= 0, all latched fields <= 0.
  - All registered outputs are 0 while in reset. stall follows its combinational equation.
- States:
  - IDLE: no transaction.
  - ISSUE: mem_req=1 with latched fields.
  - WAIT: request accepted, awaiting mem_rvalid.
- Arbitration event: occurs in IDLE, or in WAIT in the same cycle mem_rvalid=1, when if_req|d_req.
  - Winner: fetch if if_req & (~d_req | starve_cnt==MAX_WAIT); otherwise data.
  - Latch owner and attributes. Fetch latches mem_we=0, mem_be=all ones, mem_wdata=0.
  - Assert winner's gnt combinationally in that cycle.
  - Next state: ISSUE.
  - With no request: IDLE stays IDLE; WAIT goes to IDLE.
- starve_cnt, updated only at arbitration events:
  - Data wins while if_req=1: increment, saturating at MAX_WAIT.
  - Fetch wins, or if_req=0: clear to 0.
- ISSUE: mem_req=1 and fields stable until mem_gnt. On mem_gnt -> WAIT. No timeout.
- WAIT: mem_req=0.
  - On mem_rvalid: owner's rvalid=1 combinationally and owner's rdata=mem_rdata; the other requester's rvalid=0.
  - Stores also complete only on mem_rvalid (d_rvalid acknowledge).
- rdata outputs: both may carry mem_rdata continuously; consumers qualify with rvalid.
- mem_rvalid in IDLE or ISSUE is ignored: no rvalid output, no state change.
- Back-to-back: response cycle and next grant coincide. Minimum 2 cycles per transaction (ISSUE with mem_gnt, then WAIT with mem_rvalid).
- Reset mid-transaction: the transaction is abandoned with no rvalid. mem_req is 0 from the cycle after the reset edge. A late mem_rvalid is ignored.
- Dropping req before gnt is a protocol violation; behaviour is undefined.

Test Plan:
- Reset, then if_req=1, if_addr=0x100; memory gives mem_gnt in ISSUE and mem_rvalid next cycle with rdata=0x00500093 -> if_gnt at cycle 0; mem_req=1, mem_addr=0x100 at cycle 1; if_rvalid=1, if_rdata=0x00500093 at cycle 2; stall=1 in cycles 0-1, 0 at cycle 2.
- if_req and d_req (d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, d_be=0x3) rise together -> d_gnt first; mem_we=1, mem_be=0x3, mem_wdata=0xDEADBEEF; d_rvalid on ack; if_gnt in the same cycle as d_rvalid.
- d_req held high continuously, if_req high, MAX_WAIT=4 -> d_gnt at 4 consecutive arbitrations, then if_gnt at the 5th; starve_cnt returns to 0.
- mem_gnt withheld for 3 cycles in ISSUE -> mem_req and mem_addr stay stable all 3 cycles; no gnt pulses; advances on the 4th cycle when mem_gnt=1.
- rst=0 asserted in WAIT, then mem_rvalid=1 the next cycle -> no if_rvalid/d_rvalid; state IDLE; mem_req=0.
- Spurious mem_rvalid=1 in IDLE -> no rvalid outputs; state unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch requester, data requester and the shared memory port.
// The arbiter uses the slave view; requesters and memory together form the master view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_be;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  stall;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be, stall
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be, stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access; one transaction in flight,
// data has priority, fetch is forced through after MAX_WAIT consecutive losses.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned BE_W = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e              state_q, state_d;
  logic                owner_data_q, owner_data_d;
  logic [3:0]          starve_cnt_q, starve_cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;

  logic resp;
  logic arb_event;
  logic fetch_wins;

  // No handshakes are offered while reset is held, so nothing is granted that gets dropped.
  assign resp       = rst & (state_q == StWait) & bus.mem_rvalid;
  assign arb_event  = rst & ((state_q == StIdle) | resp) & (bus.if_req | bus.d_req);
  assign fetch_wins = bus.if_req & (~bus.d_req | (starve_cnt_q == 4'(MAX_WAIT)));

  assign bus.if_gnt    = arb_event & fetch_wins;
  assign bus.d_gnt     = arb_event & ~fetch_wins;
  assign bus.if_rvalid = resp & ~owner_data_q;
  assign bus.d_rvalid  = resp & owner_data_q;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;

  assign bus.mem_req   = (state_q == StIssue);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;

  assign bus.stall = bus.if_req & ~bus.if_rvalid;

  always_comb begin
    state_d      = state_q;
    owner_data_d = owner_data_q;
    starve_cnt_d = starve_cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;

    unique case (state_q)
      StIdle:  if (arb_event) state_d = StIssue;
      StIssue: if (bus.mem_gnt) state_d = StWait;
      StWait:  if (resp) state_d = arb_event ? StIssue : StIdle;
      default: state_d = StIdle;
    endcase

    if (arb_event) begin
      owner_data_d = ~fetch_wins;
      we_d         = fetch_wins ? 1'b0 : bus.d_we;
      addr_d       = fetch_wins ? bus.if_addr : bus.d_addr;
      wdata_d      = fetch_wins ? '0 : bus.d_wdata;
      be_d         = fetch_wins ? '1 : bus.d_be;
      // Only a loss while fetch is actually waiting counts towards starvation.
      if (~fetch_wins & bus.if_req) begin
        starve_cnt_d = (starve_cnt_q == 4'(MAX_WAIT)) ? starve_cnt_q : starve_cnt_q + 4'd1;
      end else begin
        starve_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      owner_data_q <= 1'b0;
      starve_cnt_q <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
    end else begin
      state_q      <= state_d;
      owner_data_q <= owner_data_d;
      starve_cnt_q <= starve_cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, starvation sequence and
// randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int unsigned MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst_v, ifr, dr, we, mg, mv;
    logic [31:0] rd;
    logic        e_ig, e_dg, e_mr, e_iv, e_dv, e_st;
    logic        e_we;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // f selects the expected latched memory fields: 0 fetch, 1 data store, 2 data load.
  function automatic vec_t mk(logic r, logic ifr, logic dr, logic we, logic mg, logic mv,
                              logic [31:0] rd, logic ig, logic dg, logic mr, logic iv,
                              logic dv, logic st, int f);
    vec_t v;
    v.rst_v = r; v.ifr = ifr; v.dr = dr; v.we = we; v.mg = mg; v.mv = mv; v.rd = rd;
    v.e_ig = ig; v.e_dg = dg; v.e_mr = mr; v.e_iv = iv; v.e_dv = dv; v.e_st = st;
    if (f == 0) begin
      v.e_we = 1'b0; v.e_addr = 32'h100; v.e_be = 4'hF; v.e_wd = 32'h0;
    end else begin
      v.e_we = (f == 1); v.e_addr = 32'h200; v.e_be = 4'h3; v.e_wd = 32'hDEADBEEF;
    end
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    rst            = v.rst_v;
    bus.if_req     = v.ifr;
    bus.if_addr    = 32'h100;
    bus.d_req      = v.dr;
    bus.d_we       = v.we;
    bus.d_addr     = 32'h200;
    bus.d_wdata    = 32'hDEADBEEF;
    bus.d_be       = 4'h3;
    bus.mem_gnt    = v.mg;
    bus.mem_rvalid = v.mv;
    bus.mem_rdata  = v.rd;
    #2;
    chk({tag, "/if_gnt"},    bus.if_gnt,    v.e_ig);
    chk({tag, "/d_gnt"},     bus.d_gnt,     v.e_dg);
    chk({tag, "/mem_req"},   bus.mem_req,   v.e_mr);
    chk({tag, "/if_rvalid"}, bus.if_rvalid, v.e_iv);
    chk({tag, "/d_rvalid"},  bus.d_rvalid,  v.e_dv);
    chk({tag, "/stall"},     bus.stall,     v.e_st);
    if (v.e_mr) begin
      chk({tag, "/mem_we"},    bus.mem_we,    v.e_we);
      chk({tag, "/mem_addr"},  bus.mem_addr,  v.e_addr);
      chk({tag, "/mem_be"},    bus.mem_be,    v.e_be);
      chk({tag, "/mem_wdata"}, bus.mem_wdata, v.e_wd);
    end
    if (v.e_iv) chk({tag, "/if_rdata"}, bus.if_rdata, v.rd);
    if (v.e_dv) chk({tag, "/d_rdata"},  bus.d_rdata,  v.rd);
  endtask

  vec_t tbl[21];
  bit   win_d[6];

  // Reference model state (transaction level)
  bit          pend, acc, own_d;
  int          losses;
  logic        m_we;
  logic [31:0] m_addr, m_wd;
  logic [3:0]  m_be;
  bit          ih, dh;

  initial begin
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0;
    bus.d_wdata = 0; bus.d_be = 0; bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;

    //            rst ifr dr we mg mv rd            ig dg mr iv dv st f
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 0, 0, 0, 32'h0,        1, 0, 0, 0, 0, 1, 0);
    tbl[3]  = mk(1, 1, 0, 0, 1, 0, 32'h0,        0, 0, 1, 0, 0, 1, 0);
    tbl[4]  = mk(1, 0, 0, 0, 0, 1, 32'h00500093, 0, 0, 0, 1, 0, 0, 0);
    tbl[5]  = mk(1, 0, 0, 0, 0, 1, 32'h11111111, 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 0, 0, 0, 1, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 1, 1, 1, 0, 0, 32'h0,        0, 1, 0, 0, 0, 1, 1);
    tbl[8]  = mk(1, 1, 0, 1, 1, 0, 32'h0,        0, 0, 1, 0, 0, 1, 1);
    tbl[9]  = mk(1, 1, 0, 0, 0, 1, 32'h12345678, 1, 0, 0, 0, 1, 1, 0);
    tbl[10] = mk(1, 0, 0, 0, 1, 0, 32'h0,        0, 0, 1, 0, 0, 0, 0);
    tbl[11] = mk(1, 0, 0, 0, 0, 1, 32'hCAFEF00D, 0, 0, 0, 1, 0, 0, 0);
    tbl[12] = mk(1, 0, 1, 0, 0, 0, 32'h0,        0, 1, 0, 0, 0, 0, 2);
    tbl[13] = mk(1, 0, 0, 0, 0, 1, 32'h22222222, 0, 0, 1, 0, 0, 0, 2);
    tbl[14] = mk(1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 1, 0, 0, 0, 2);
    tbl[15] = mk(1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 1, 0, 0, 0, 2);
    tbl[16] = mk(1, 0, 0, 0, 1, 0, 32'h0,        0, 0, 1, 0, 0, 0, 2);
    tbl[17] = mk(1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0);
    tbl[19] = mk(1, 0, 0, 0, 0, 1, 32'h00000BAD, 0, 0, 0, 0, 0, 0, 0);
    tbl[20] = mk(1, 0, 0, 0, 1, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 21; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Starvation: data wins MAX_WAIT arbitrations in a row, then fetch, then data again.
    win_d = '{1, 1, 1, 1, 0, 1};
    apply(mk(1, 1, 1, 0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 1, 0), "stv0");
    for (int k = 1; k < 6; k++) begin
      apply(mk(1, 1, 1, 0, 1, 0, 32'h0, 0, 0, 1, 0, 0, 1, win_d[k-1] ? 2 : 0),
            $sformatf("stv%0d_iss", k));
      apply(mk(1, 1, 1, 0, 0, 1, 32'hA000_0000 + k, !win_d[k], win_d[k], 0, !win_d[k-1],
               win_d[k-1], win_d[k-1], 0), $sformatf("stv%0d_rsp", k));
    end
    apply(mk(1, 0, 0, 0, 1, 0, 32'h0, 0, 0, 1, 0, 0, 0, 2), "stv_drain_iss");
    apply(mk(1, 0, 0, 0, 0, 1, 32'h5A5A5A5A, 0, 0, 0, 0, 1, 0, 0), "stv_drain_rsp");
    apply(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0), "rnd_reset");

    // Randomized traffic against the reference model
    pend = 0; acc = 0; own_d = 0; losses = 0; ih = 0; dh = 0;
    m_we = 0; m_addr = 0; m_wd = 0; m_be = 0;
    for (int c = 0; c < 400; c++) begin
      bit resp, arb, fw, e_ig, e_dg, e_mr, e_iv, e_dv;
      @(negedge clk);
      rst = 1'b1;
      if (!ih && $urandom_range(0, 2) == 0) begin
        ih = 1; bus.if_addr = $urandom;
      end
      if (!dh && $urandom_range(0, 2) == 0) begin
        dh = 1; bus.d_we = 1'($urandom_range(0, 1)); bus.d_addr = $urandom;
        bus.d_wdata = $urandom; bus.d_be = 4'($urandom);
      end
      bus.if_req     = ih;
      bus.d_req      = dh;
      bus.mem_gnt    = 1'($urandom_range(0, 1));
      bus.mem_rvalid = ($urandom_range(0, 2) != 0);
      bus.mem_rdata  = $urandom;
      #2;
      resp = pend && acc && bus.mem_rvalid;
      arb  = (!pend || resp) && (ih || dh);
      fw   = ih && (!dh || losses >= int'(MAX_WAIT));
      e_ig = arb && fw;
      e_dg = arb && !fw;
      e_mr = pend && !acc;
      e_iv = resp && !own_d;
      e_dv = resp && own_d;
      chk($sformatf("rnd%0d/if_gnt", c),    bus.if_gnt,    e_ig);
      chk($sformatf("rnd%0d/d_gnt", c),     bus.d_gnt,     e_dg);
      chk($sformatf("rnd%0d/mem_req", c),   bus.mem_req,   e_mr);
      chk($sformatf("rnd%0d/if_rvalid", c), bus.if_rvalid, e_iv);
      chk($sformatf("rnd%0d/d_rvalid", c),  bus.d_rvalid,  e_dv);
      chk($sformatf("rnd%0d/stall", c),     bus.stall,     ih && !e_iv);
      if (e_mr) begin
        chk($sformatf("rnd%0d/mem_fields", c),
            {bus.mem_we, bus.mem_be, bus.mem_addr}, {m_we, m_be, m_addr});
        chk($sformatf("rnd%0d/mem_wdata", c), bus.mem_wdata, m_wd);
      end
      if (e_iv) chk($sformatf("rnd%0d/if_rdata", c), bus.if_rdata, bus.mem_rdata);
      if (e_dv) chk($sformatf("rnd%0d/d_rdata", c),  bus.d_rdata,  bus.mem_rdata);

      if (pend && !acc && bus.mem_gnt) acc = 1;
      if (resp) pend = 0;
      if (arb) begin
        pend  = 1;
        acc   = 0;
        own_d = !fw;
        if (fw) begin
          m_we = 0; m_addr = bus.if_addr; m_wd = 0; m_be = 4'hF; ih = 0;
        end else begin
          m_we = bus.d_we; m_addr = bus.d_addr; m_wd = bus.d_wdata; m_be = bus.d_be; dh = 0;
        end
        losses = (!fw && bus.if_req) ? losses + 1 : 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
